// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack
// handshake, presents them to control, and computes the next PC on retire.
// Optional build macro: MISALIGN_TRAP_EN adds misalign_out and halts on a
// misaligned next PC; without it next_pc[1:0] is forced to zero.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 15
) (
    input  logic        clock_in,
    input  logic        reset_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    output logic        instr_valid_out,
    input  logic        instr_ready_in,
    output logic [31:0] instr_out,
    output logic [5:0]  opcode_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    input  logic        branch_in,
    input  logic        jump_in,
    input  logic        zero_in,
    output logic        timeout_out
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign_out
`endif
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic             req_q, req_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pc_plus4;
    logic [31:0]      next_pc;
`ifdef MISALIGN_TRAP_EN
    logic             misalign_q, misalign_d;
`endif

    assign pc_plus4 = pc_q + 32'd4;

    // Next-PC selection: jump beats branch, branch needs zero flag.
    always_comb begin
        if (jump_in) begin
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (branch_in && zero_in) begin
            next_pc = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        end else begin
            next_pc = pc_plus4;
        end
`ifndef MISALIGN_TRAP_EN
        next_pc[1:0] = 2'b00;
`endif
    end

    // Fetch FSM next-state and registered-output values.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        req_d     = 1'b0;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
`ifdef MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                cnt_d   = '0;
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack_in) begin
                    instr_d = imem_data_in;
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end else if (cnt_q == CNT_W'(IMEM_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    req_d = 1'b1;
                end
            end
            ISSUE: begin
                if (instr_ready_in) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
`ifdef MISALIGN_TRAP_EN
                    if (next_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
`else
                    pc_d    = next_pc;
                    state_d = FETCH;
`endif
                end
            end
            HALT: begin
                req_d = req_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, asynchronously reset.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign imem_req_out    = req_q;
    assign imem_addr_out   = pc_q;
    assign instr_valid_out = valid_q;
    assign instr_out       = instr_q;
    assign opcode_out      = instr_q[31:26];
    assign pc_out          = pc_q;
    assign pc_plus4_out    = pc_plus4;
    assign timeout_out     = timeout_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_out    = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: three instances with different reset PCs share the
// memory/control stimulus; only the one out of reset is exercised.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic [2:0]  rst = 3'b111;
    logic        ack = 1'b0;
    logic [31:0] data = '0;
    logic        ready = 1'b0;
    logic        br = 1'b0, jmp = 1'b0, zero = 1'b0;

    logic        req   [3];
    logic [31:0] addr  [3];
    logic        valid [3];
    logic [31:0] instr [3];
    logic [5:0]  opc   [3];
    logic [31:0] pc    [3];
    logic [31:0] pc4   [3];
    logic        tmo   [3];

    int vectors = 0;
    int miscompares = 0;
    int sel = 0;
    logic [31:0] mpc;
    logic [31:0] w;

    always #5 clk = ~clk;

    localparam logic [31:0] RPC0 = 32'h0000_0000;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFFC;
    localparam logic [31:0] RPC2 = 32'h1000_0020;

    fetch_unit #(.RESET_PC(RPC0), .IMEM_TIMEOUT(15)) u0 (
        .clock_in(clk), .reset_in(rst[0]), .imem_req_out(req[0]), .imem_addr_out(addr[0]),
        .imem_ack_in(ack), .imem_data_in(data), .instr_valid_out(valid[0]),
        .instr_ready_in(ready), .instr_out(instr[0]), .opcode_out(opc[0]), .pc_out(pc[0]),
        .pc_plus4_out(pc4[0]), .branch_in(br), .jump_in(jmp), .zero_in(zero),
        .timeout_out(tmo[0]));

    fetch_unit #(.RESET_PC(RPC1), .IMEM_TIMEOUT(15)) u1 (
        .clock_in(clk), .reset_in(rst[1]), .imem_req_out(req[1]), .imem_addr_out(addr[1]),
        .imem_ack_in(ack), .imem_data_in(data), .instr_valid_out(valid[1]),
        .instr_ready_in(ready), .instr_out(instr[1]), .opcode_out(opc[1]), .pc_out(pc[1]),
        .pc_plus4_out(pc4[1]), .branch_in(br), .jump_in(jmp), .zero_in(zero),
        .timeout_out(tmo[1]));

    fetch_unit #(.RESET_PC(RPC2), .IMEM_TIMEOUT(15)) u2 (
        .clock_in(clk), .reset_in(rst[2]), .imem_req_out(req[2]), .imem_addr_out(addr[2]),
        .imem_ack_in(ack), .imem_data_in(data), .instr_valid_out(valid[2]),
        .instr_ready_in(ready), .instr_out(instr[2]), .opcode_out(opc[2]), .pc_out(pc[2]),
        .pc_plus4_out(pc4[2]), .branch_in(br), .jump_in(jmp), .zero_in(zero),
        .timeout_out(tmo[2]));

    // Reference next-PC rule written as plain arithmetic on the retiring word.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                               input logic b, input logic j, input logic z);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        off = int'($signed(word[15:0])) * 4;
        if (j)           return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
        else if (b && z) return seq + 32'(off);
        else             return seq;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset everything, release one instance and check the start-up timing.
    task automatic do_reset(input int s, input logic [31:0] rpc);
        rst = 3'b111; ack = 1'b0; ready = 1'b0; br = 1'b0; jmp = 1'b0; zero = 1'b0;
        tick(); tick();
        chk("rst_pc", pc[s], rpc);
        chk("rst_req", 32'(req[s]), 32'd0);
        chk("rst_valid", 32'(valid[s]), 32'd0);
        chk("rst_instr", instr[s], 32'd0);
        chk("rst_timeout", 32'(tmo[s]), 32'd0);
        sel = s;
        rst[s] = 1'b0;
        tick();
        chk("idle_req", 32'(req[s]), 32'd0);
        tick();
        chk("first_req", 32'(req[s]), 32'd1);
        chk("first_addr", addr[s], rpc);
    endtask

    // Serve one fetch with the given ack latency, then sit in issue a while.
    task automatic fetch(input logic [31:0] word, input int lat, input logic [31:0] exp_pc);
        int n = 0;
        int k;
        while (req[sel] !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        chk("req_seen", 32'(req[sel]), 32'd1);
        chk("fetch_addr", addr[sel], exp_pc);
        chk("fetch_pc4", pc4[sel], exp_pc + 32'd4);
        for (int i = 1; i < lat; i++) begin
            ready = 1'($urandom_range(0, 1));
            tick();
            chk("req_hold", 32'(req[sel]), 32'd1);
        end
        ready = 1'b0;
        ack = 1'b1;
        data = word;
        tick();
        ack = 1'b0;
        data = $urandom;
        chk("ack_req_drop", 32'(req[sel]), 32'd0);
        chk("ack_valid", 32'(valid[sel]), 32'd1);
        chk("ack_instr", instr[sel], word);
        chk("ack_opcode", 32'(opc[sel]), word >> 26);
        k = $urandom_range(0, 3);
        for (int i = 0; i < k; i++) begin
            ack = 1'($urandom_range(0, 1));
            tick();
            chk("issue_valid", 32'(valid[sel]), 32'd1);
            chk("issue_instr", instr[sel], word);
            chk("issue_pc", pc[sel], exp_pc);
        end
        ack = 1'b0;
    endtask

    task automatic retire(input logic b, input logic j, input logic z);
        br = b; jmp = j; zero = z; ready = 1'b1;
        tick();
        ready = 1'b0;
        br = 1'($urandom); jmp = 1'($urandom); zero = 1'($urandom);
        chk("retire_valid", 32'(valid[sel]), 32'd0);
        chk("retire_req", 32'(req[sel]), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic b, j, z;

        // Start-up, two-cycle ack, sequential addresses 0, 4, 8.
        do_reset(0, RPC0);
        fetch($urandom, 2, 32'h0000_0000);
        retire(1'b0, 1'b0, 1'b1);
        fetch($urandom, 1, 32'h0000_0004);
        retire(1'b0, 1'b0, 1'b0);
        // Jump from 0x8 to 0x10.
        fetch(32'h0800_0004, 3, 32'h0000_0008);
        retire(1'b0, 1'b1, 1'b0);
        // Branch taken back to itself, then not taken.
        fetch(32'h1000_FFFF, 2, 32'h0000_0010);
        retire(1'b1, 1'b0, 1'b1);
        fetch(32'h1000_FFFF, 1, 32'h0000_0010);
        retire(1'b1, 1'b0, 1'b0);

        // Random instruction stream against the reference model.
        mpc = 32'h0000_0014;
        for (int i = 0; i < 30; i++) begin
            w = $urandom;
            b = 1'($urandom_range(0, 1));
            z = 1'($urandom_range(0, 1));
            j = ($urandom_range(0, 3) == 0);
            fetch(w, $urandom_range(1, 4), mpc);
            retire(b, j, z);
            mpc = model_next(mpc, w, b, j, z);
        end

        // No ack: fifteen fetch cycles then sticky timeout and halt.
        for (int i = 0; i < 14; i++) tick();
        chk("pre_timeout", 32'(tmo[0]), 32'd0);
        chk("pre_timeout_req", 32'(req[0]), 32'd1);
        chk("pre_timeout_addr", addr[0], mpc);
        tick();
        chk("timeout", 32'(tmo[0]), 32'd1);
        chk("timeout_req", 32'(req[0]), 32'd0);
        chk("timeout_valid", 32'(valid[0]), 32'd0);
        ack = 1'b1;
        ready = 1'b1;
        tick(); tick();
        ack = 1'b0;
        ready = 1'b0;
        chk("halt_timeout", 32'(tmo[0]), 32'd1);
        chk("halt_req", 32'(req[0]), 32'd0);
        chk("halt_valid", 32'(valid[0]), 32'd0);
        chk("halt_pc", pc[0], mpc);

        // Reset while fetching with an ack on the wire.
        do_reset(0, RPC0);
        fetch($urandom, 1, 32'h0000_0000);
        retire(1'b0, 1'b0, 1'b0);
        tick();
        chk("midfetch_req", 32'(req[0]), 32'd1);
        chk("midfetch_pc", pc[0], 32'h0000_0004);
        ack = 1'b1;
        data = 32'hDEAD_BEEF;
        #2;
        rst[0] = 1'b1;
        #1;
        chk("async_req_drop", 32'(req[0]), 32'd0);
        chk("async_pc", pc[0], RPC0);
        tick();
        chk("reset_ack_discard_valid", 32'(valid[0]), 32'd0);
        chk("reset_ack_discard_instr", instr[0], 32'd0);
        ack = 1'b0;

        // PC wrap from the top of the address space.
        do_reset(1, RPC1);
        fetch($urandom, 1, RPC1);
        retire(1'b0, 1'b0, 1'b0);
        fetch($urandom, 2, 32'h0000_0000);
        retire(1'b0, 1'b0, 1'b0);

        // Jump wins over a taken branch.
        do_reset(2, RPC2);
        fetch(32'h0800_0040, 1, RPC2);
        retire(1'b1, 1'b1, 1'b1);
        fetch($urandom, 1, 32'h1000_0100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
